// File: rtl/obu_bit_reader_if.sv
// rtl/obu_bit_reader_if.sv - byte-in / window-out bundle for the OBU bit reader
//
// Purpose: groups the byte stream handshake, the consume controls and the
// window/status outputs of obu_bit_reader into one bundle.
// Ports (all signals, no clock):
//   in_data/in_valid/in_ready  byte stream into the reader, MSB first in stream
//   flush, pop, pad, pad_len, align  consume controls from the parser
//   data_out, avail, bit_count, total_bits, err  window and status to the parser
// Modports: master = parser/producer side, slave = bit reader.
interface obu_bit_reader_if #(
  parameter int DATA_W = 32,
  parameter int BUF_W  = 64
);
  localparam int PAD_LEN_WIDTH = $clog2(DATA_W + 1);
  localparam int CNT_W         = $clog2(BUF_W + 1);

  logic [7:0]               in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     flush;
  logic [DATA_W-1:0]        data_out;
  logic                     avail;
  logic                     pad;
  logic [PAD_LEN_WIDTH-1:0] pad_len;
  logic                     pop;
  logic                     align;
  logic [CNT_W-1:0]         bit_count;
  logic [31:0]              total_bits;
  logic                     err;

  modport master (
    output in_data, in_valid, flush, pad, pad_len, pop, align,
    input  in_ready, data_out, avail, bit_count, total_bits, err
  );

  modport slave (
    input  in_data, in_valid, flush, pad, pad_len, pop, align,
    output in_ready, data_out, avail, bit_count, total_bits, err
  );
endinterface

// File: rtl/obu_bit_reader.sv
// rtl/obu_bit_reader.sv - left-justified bit buffer feeding the OBU parser
//
// Purpose: accepts bytes into a left-justified bit buffer and presents the
// next DATA_W stream bits to the parser, which consumes them by pop (DATA_W),
// pad (pad_len) or align (to the next byte boundary of the consumed position).
// Ports:
//   clk  clock, all state on rising edge
//   rst  asynchronous active-high reset
//   bus  obu_bit_reader_if.slave: byte input handshake, consume controls,
//        data_out/avail window, bit_count, total_bits, sticky err
module obu_bit_reader #(
  parameter int DATA_W = 32,
  parameter int BUF_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  obu_bit_reader_if.slave   bus
);
  localparam int PAD_LEN_WIDTH = $clog2(DATA_W + 1);
  localparam int CNT_W         = $clog2(BUF_W + 1);

  localparam logic [CNT_W-1:0]         DATA_W_C  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]         FULL_LIM  = CNT_W'(BUF_W - 8);
  localparam logic [PAD_LEN_WIDTH-1:0] PAD_MAX   = PAD_LEN_WIDTH'(DATA_W);

  logic [BUF_W-1:0] bit_buf;
  logic [BUF_W-1:0] buf_nxt;
  logic [BUF_W-1:0] byte_ext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] align_n;
  logic [2:0]       align_lo;
  logic [31:0]      total;
  logic [31:0]      total_nxt;
  logic             err_q;
  logic             err_nxt;
  logic             avail;
  logic             ready;
  logic             accept;
  logic             pad_over;

  assign avail    = (cnt >= DATA_W_C);
  // flush forces ready low so a byte offered alongside it is never taken.
  assign ready    = !bus.flush && (cnt <= FULL_LIM);
  assign accept   = bus.in_valid && ready;
  // (8 - total mod 8) mod 8 is just the 3-bit two's complement of total[2:0].
  assign align_lo = 3'd0 - total[2:0];
  assign align_n  = CNT_W'(align_lo);
  assign pad_over = (bus.pad_len > PAD_MAX);

  always_comb begin
    n       = '0;
    err_nxt = err_q;
    if (bus.pop) begin
      if (avail) n = DATA_W_C;
      else       err_nxt = 1'b1;
    end else if (bus.pad) begin
      if (bus.pad_len != '0) begin
        if (!avail) begin
          err_nxt = 1'b1;
        end else if (pad_over) begin
          n       = DATA_W_C;
          err_nxt = 1'b1;
        end else begin
          n = CNT_W'(bus.pad_len);
        end
      end
    end else if (bus.align) begin
      // align needs at most 7 bits, so a short buffer can still satisfy it.
      if (avail || (cnt >= align_n)) n = align_n;
      else                           err_nxt = 1'b1;
    end

    // n never exceeds cnt, so cnt - n is the fill level after the consume and
    // the new byte lands directly below the surviving bits.
    byte_ext  = {bus.in_data, {(BUF_W-8){1'b0}}} >> (cnt - n);
    buf_nxt   = bit_buf << n;
    if (accept) buf_nxt = buf_nxt | byte_ext;
    cnt_nxt   = cnt - n + (accept ? CNT_W'(8) : CNT_W'(0));
    total_nxt = total + 32'(n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_buf <= '0;
      cnt     <= '0;
      total   <= '0;
      err_q   <= 1'b0;
    end else if (bus.flush) begin
      bit_buf <= '0;
      cnt     <= '0;
      total   <= '0;
      err_q   <= 1'b0;
    end else begin
      bit_buf <= buf_nxt;
      cnt     <= cnt_nxt;
      total   <= total_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.data_out   = bit_buf[BUF_W-1 -: DATA_W];
  assign bus.avail      = avail;
  assign bus.in_ready   = ready;
  assign bus.bit_count  = cnt;
  assign bus.total_bits = total;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_obu_bit_reader.sv
// tb/tb_obu_bit_reader.sv - self-checking bench for obu_bit_reader
module tb_obu_bit_reader;
  localparam int DW = 32;
  localparam int BW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  obu_bit_reader_if #(.DATA_W(DW), .BUF_W(BW)) bus ();
  obu_bit_reader #(.DATA_W(DW), .BUF_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bit          q[$];
  logic [7:0]  sent_bytes[$];
  int unsigned m_total;
  bit          m_err;
  int          n_checks;
  int          n_pass;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < DW; i++) w[DW-1-i] = (i < q.size()) ? q[i] : 1'b0;
    return w;
  endfunction

  task automatic check_state(input string tag);
    check_val({tag, ".bit_count"}, 64'(bus.bit_count), 64'(q.size()));
    check_val({tag, ".avail"}, 64'(bus.avail), 64'(q.size() >= DW));
    check_val({tag, ".data_out"}, 64'(bus.data_out), 64'(model_word()));
    check_val({tag, ".total_bits"}, 64'(bus.total_bits), 64'(m_total));
    check_val({tag, ".err"}, 64'(bus.err), 64'(m_err));
    check_val({tag, ".in_ready"}, 64'(bus.in_ready), 64'(!bus.flush && q.size() <= BW - 8));
  endtask

  // Called just after a falling edge: drives one cycle of stimulus, updates the
  // bit-queue scoreboard, and checks the registered outputs one edge later.
  task automatic drive(input bit v, input logic [7:0] d, input bit fl, input bit pp,
                       input bit pd, input int pl, input bit al, input string tag);
    int  n;
    int  cnt;
    bit  av;
    bit  exp_ready;
    int  an;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.flush    = fl;
    bus.pop      = pp;
    bus.pad      = pd;
    bus.pad_len  = pl[5:0];
    bus.align    = al;
    #1;
    cnt       = q.size();
    av        = (cnt >= DW);
    exp_ready = !fl && (cnt <= BW - 8);
    check_val({tag, ".ready_pre"}, 64'(bus.in_ready), 64'(exp_ready));
    n = 0;
    if (fl) begin
      q.delete();
      m_total = 0;
      m_err   = 1'b0;
    end else begin
      if (pp) begin
        if (av) n = DW; else m_err = 1'b1;
      end else if (pd) begin
        if (pl != 0) begin
          if (!av) m_err = 1'b1;
          else if (pl > DW) begin n = DW; m_err = 1'b1; end
          else n = pl;
        end
      end else if (al) begin
        an = (8 - int'(m_total % 8)) % 8;
        if (av || cnt >= an) n = an; else m_err = 1'b1;
      end
      for (int i = 0; i < n; i++) void'(q.pop_front());
      m_total += n;
      if (v && exp_ready) for (int b = 7; b >= 0; b--) q.push_back(d[b]);
    end
    @(posedge clk);
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, tag);
  endtask

  task automatic feed(input logic [7:0] d, input string tag);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0, 0, 1'b0, tag);
  endtask

  task automatic do_flush();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, "flush");
  endtask

  initial begin
    logic [7:0]  bv;
    logic [31:0] w;
    bit          pp;
    n_checks = 0;
    n_pass   = 0;
    m_total  = 0;
    m_err    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.flush    = 1'b0;
    bus.pop      = 1'b0;
    bus.pad      = 1'b0;
    bus.pad_len  = '0;
    bus.align    = 1'b0;

    #3;
    check_state("reset");
    check_val("reset.data_out_zero", 64'(bus.data_out), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fill with four bytes, then a fifth; pad 4, align.
    feed(8'h12, "fill0");
    feed(8'h34, "fill1");
    feed(8'h56, "fill2");
    feed(8'h78, "fill3");
    check_val("fill.word", 64'(bus.data_out), 64'h12345678);
    check_val("fill.bc", 64'(bus.bit_count), 64'd32);
    check_val("fill.avail", 64'(bus.avail), 64'd1);
    feed(8'h9A, "fill4");
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4, 1'b0, "pad4");
    check_val("pad4.word", 64'(bus.data_out), 64'h23456789);
    check_val("pad4.bc", 64'(bus.bit_count), 64'd36);
    check_val("pad4.total", 64'(bus.total_bits), 64'd4);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, "align");
    check_val("align.word", 64'(bus.data_out), 64'h3456789A);
    check_val("align.total", 64'(bus.total_bits), 64'd8);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, "align_noop");

    // Error cases.
    do_flush();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, "pop_empty");
    check_val("pop_empty.err", 64'(bus.err), 64'd1);
    do_flush();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, "pad0_empty");
    for (int i = 0; i < 5; i++) feed(8'(8'hC0 + i), "pfill");
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 40, 1'b0, "pad40");
    check_val("pad40.bc", 64'(bus.bit_count), 64'd8);
    check_val("pad40.err", 64'(bus.err), 64'd1);
    do_flush();
    check_val("flush.err", 64'(bus.err), 64'd0);
    check_val("flush.bc", 64'(bus.bit_count), 64'd0);
    check_val("flush.total", 64'(bus.total_bits), 64'd0);

    // Full boundary.
    for (int i = 0; i < 7; i++) feed(8'(8'h10 + i), "full_fill");
    check_val("full56.ready", 64'(bus.in_ready), 64'd1);
    feed(8'h17, "full_last");
    check_val("full64.bc", 64'(bus.bit_count), 64'd64);
    check_val("full64.ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 0, 1'b0, "full_pop_blocked");
    drive(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 0, 1'b0, "full_pop_accept");
    check_val("full_pop.bc", 64'(bus.bit_count), 64'd8);

    // Streaming: byte every cycle, pop whenever a word is available.
    do_flush();
    sent_bytes.delete();
    for (int c = 0; c < 120; c++) begin
      bv = 8'($urandom);
      pp = (q.size() >= DW);
      if (pp) begin
        w = {sent_bytes[0], sent_bytes[1], sent_bytes[2], sent_bytes[3]};
        check_val("stream.word", 64'(bus.data_out), 64'(w));
        for (int k = 0; k < 4; k++) void'(sent_bytes.pop_front());
      end
      if (q.size() <= BW - 8) sent_bytes.push_back(bv);
      drive(1'b1, bv, 1'b0, pp, 1'b0, 0, 1'b0, "stream");
      check_val("stream.bc_max", 64'(bus.bit_count <= 7'(BW)), 64'd1);
    end

    // Random mix of all controls, including error-raising ones.
    for (int c = 0; c < 200; c++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 30) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 40)), ($urandom_range(0, 3) == 0), "mix");
    end

    // Asynchronous reset mid-stream with 48 bits buffered.
    do_flush();
    for (int i = 0; i < 6; i++) feed(8'(8'h60 + i), "rfill");
    check_val("rfill.bc", 64'(bus.bit_count), 64'd48);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_total = 0;
    m_err   = 1'b0;
    check_val("arst.bc", 64'(bus.bit_count), 64'd0);
    check_val("arst.data_out", 64'(bus.data_out), 64'd0);
    check_val("arst.avail", 64'(bus.avail), 64'd0);
    check_val("arst.ready", 64'(bus.in_ready), 64'd1);
    check_val("arst.total", 64'(bus.total_bits), 64'd0);
    check_val("arst.err", 64'(bus.err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    feed(8'hA5, "post_rst");
    check_val("post_rst.word", 64'(bus.data_out), 64'hA5000000);
    check_val("post_rst.bc", 64'(bus.bit_count), 64'd8);
    idle("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/obu_bit_reader.md
OBU_BIT_READER -- requirements
Module: obu_bit_reader

Interface
REQ-001 Parameter: DATA_W, default PARSER_DATA_WIDTH (32, obu_parser_pkg), width of the parser-facing window.
REQ-002 Parameter: BUF_W, default 64, internal bit buffer capacity in bits; SHALL be a multiple of 8 and >= DATA_W+8.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  8  next bitstream byte, MSB is the first bit in stream order.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  byte is accepted when in_valid && in_ready at a clock edge.
REQ-008 flush  input  1  synchronous discard of all buffered bits.
REQ-009 data_out  output  DATA_W  next DATA_W stream bits, first bit at data_out[DATA_W-1].
REQ-010 avail  output  1  buffered bit count >= DATA_W; data_out is meaningful.
REQ-011 pad  input  1  consume pad_len bits this cycle.
REQ-012 pad_len  input  PAD_LEN_WIDTH  bit count for pad, range 0..DATA_W.
REQ-013 pop  input  1  consume DATA_W bits this cycle.
REQ-014 align  input  1  consume bits up to the next byte boundary of the consumed-bit position.
REQ-015 bit_count  output  $clog2(BUF_W+1)  bits currently buffered.
REQ-016 total_bits  output  32  bits consumed since reset/flush, wraps modulo 2^32.
REQ-017 err  output  1  sticky protocol error flag.

Function
REQ-018 Buffer SHALL be left-justified: data_out = buf[BUF_W-1 -: DATA_W]; avail = (bit_count >= DATA_W); both derived from registers only.
REQ-019 in_ready SHALL be (bit_count <= BUF_W-8) and SHALL NOT depend on same-cycle consume inputs.
REQ-020 Consume amount n per cycle, priority order: flush (discard all) > pop (n=DATA_W) > pad (n=pad_len) > align (n=(8 - total_bits[2:0]) mod 8) > none (n=0).
REQ-021 Consume SHALL take effect only when avail=1; a pop, pad or align with avail=0 SHALL be ignored and SHALL set err, except that align with bit_count >= n SHALL be honoured.
REQ-022 pad with pad_len > DATA_W SHALL consume DATA_W bits and set err; pad with pad_len = 0 SHALL consume nothing, no error.
REQ-023 On consume: buf <= buf << n; bit_count <= bit_count - n; total_bits <= total_bits + n.
REQ-024 On byte accept in the same cycle as a consume, the byte SHALL be placed at bit positions [BUF_W-1-(bit_count-n) -: 8] of the shifted buffer; bit_count ends as bit_count - n + 8.
REQ-025 Consume and byte accept in the same cycle SHALL both take effect; no bit is lost or duplicated.
REQ-026 Bits below position BUF_W-1-bit_count SHALL be zero after every update.
REQ-027 flush SHALL clear buf, bit_count and total_bits next cycle; a byte offered during flush SHALL NOT be accepted (in_ready irrelevant, byte dropped only if in_valid && in_ready, so in_ready SHALL be forced 0 while flush=1).
REQ-028 err SHALL remain set until rst or flush.
REQ-029 Latency: accepted byte visible on data_out and counted in bit_count one cycle after the accepting edge; consume reflected one cycle after the edge.
REQ-030 Full boundary: with bit_count = BUF_W-8, in_ready=1; at BUF_W-7..BUF_W, in_ready=0.

Reset
REQ-031 While rst=1: buf=0, bit_count=0, total_bits=0, err=0; hence data_out=0, avail=0, in_ready=1.
REQ-032 Reset asserted mid-stream SHALL discard all buffered bits immediately and asynchronously.

Verification
REQ-033 Reset, feed bytes 0x12,0x34,0x56,0x78 -> after 4th accept +1 cycle: avail=1, data_out=0x12345678, bit_count=32.
REQ-034 With 0x12345678 9A buffered (40 bits), pad pad_len=4 -> data_out=0x23456789, bit_count=36, total_bits=4; then align -> total_bits=8, data_out=0x3456789A.
REQ-035 Continuous in_valid=1 with pop every cycle avail=1 -> throughput stable, bit_count never exceeds BUF_W, popped words reproduce byte stream exactly.
REQ-036 Fill to bit_count=56 -> in_ready=1; one more byte -> bit_count=64, in_ready=0; pop same cycle as next offered byte only when in_ready=1.
REQ-037 pop with avail=0 -> no state change, err=1; pad pad_len=40 with avail=1 -> 32 bits consumed, err=1; flush -> err=0, bit_count=0, total_bits=0.
REQ-038 Assert rst for one cycle with bit_count=48 -> all outputs at reset values; subsequent byte 0xA5 accepted normally.
